ssd_display_scheduler: RTL and testbench
========================================

Name: ssd_display_scheduler

Overview:
- Controller for the 4-digit seven-segment display of the FPGA build.
- Accepts a binary value (such as the core's debug/ssd output) through a valid/ready handshake.
- Converts the value to BCD with a sequential double-dabble FSM, then time-multiplexes the four digits onto shared anode/segment lines.
- The display register holds the previous value until a conversion finishes, so the display never shows a half-converted number.

Parameters:
- DATA_W, 13: width of the input value; legal range 1..13, so the maximum value of 8191 always fits in 4 digits.
- REFRESH_DIV, 100000: clk cycles per digit slot; must be at least 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- value_in  in  DATA_W  binary value to display
- value_valid  in  1  source offers value_in
- value_ready  out  1  block can accept a value (state IDLE)
- conv_done  out  1  one-cycle pulse when a new value is committed to the display
- blank_en  in  1  blank leading zeros; digit 0 is never blanked
- anode  out  4  active-low digit enable, one-hot; bit 0 is the rightmost digit
- seg  out  7  active-low segments, ordered {g,f,e,d,c,b,a}

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset state:
  - FSM goes to IDLE; value_ready = 1; conv_done = 0.
  - Display BCD register = 0; shift register = 0.
  - Refresh counter = 0; digit index = 0.
  - anode = 4'b1111; seg = 7'b1111111.
- Reset mid-conversion aborts the conversion and the display returns to 0.

- FSM states: IDLE, SHIFT, COMMIT.
- IDLE:
  - value_ready = 1.
  - On value_valid & value_ready: latch value_in, clear the 16-bit BCD accumulator, load the shift counter with DATA_W, go to SHIFT.
- SHIFT (each cycle):
  - Add 3 to every BCD nibble that is >= 5.
  - Then shift {bcd, bin} left by 1, with the bin MSB entering bcd bit 0.
  - Decrement the counter. When the counter reaches 1 on this cycle, go to COMMIT.
- COMMIT:
  - Copy the BCD accumulator into the display register.
  - Pulse conv_done = 1 for this one cycle.
  - Go to IDLE.
- Latency: the handshake edge is cycle 0; SHIFT occupies cycles 1..DATA_W; conv_done is high in cycle DATA_W+1; value_ready is high again in cycle DATA_W+2.
- value_valid while not ready is ignored and nothing is queued; the source must hold its request until it sees ready.
- value_valid held high continuously gives back-to-back conversions with exactly one IDLE cycle between them.

- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - At terminal count, anode and seg are registered for the current digit index; the index then increments mod 4 (3 -> 0).
  - The first digit lights REFRESH_DIV cycles after reset, showing digit 0.
  - The scan runs continuously and independently of the FSM. A display-register update takes effect at the next digit load.
- Segment encoding (active low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibble codes 10..15 are unreachable; if they appear, drive all segments off.
- Blanking:
  - When blank_en = 1, a digit i > 0 whose nibble and all higher nibbles are 0 drives seg = 7'b1111111. Its anode is still asserted, so the scan timing is unchanged.
  - blank_en is sampled at each digit load.

Decomposition:
- Shared package ssd_pkg:
  - state enum {IDLE, SHIFT, COMMIT}
  - SEG_OFF = 7'b1111111, ANODE_OFF = 4'b1111
  - 7-segment digit lookup constants
  - NUM_DIGITS = 4
- Sub-module bcd_converter: holds the double-dabble FSM and its handshake (value_in/valid/ready -> bcd_out, done).
- The scheduler top keeps the refresh counter, the digit mux and blanking.

Test Plan (REFRESH_DIV = 4 unless stated otherwise):
- Reset, then 20 idle cycles -> anode/seg stay off for 4 cycles, then anode steps 1110, 1101, 1011, 0111, 1110… every 4 cycles with seg = 1000000 on each digit; value_ready = 1.
- Send value 1234 -> conv_done pulses exactly 14 cycles after the handshake; the scan then shows digit0=4 (0011001), digit1=3, digit2=2, digit3=1.
- Send 8191, then send 0 with blank_en = 1 -> the first value displays 8,1,9,1; the second shows digit0 = 0 and digits 1..3 with seg = 1111111.
- Send 1234 with blank_en = 1, then 5 -> 1234 is fully shown; for 5 only digit0 is lit with 0010010.
- Hold value_valid high and change value_in during SHIFT -> the change is ignored; value_ready stays 0 for 14 cycles; the next value is accepted one cycle after conv_done.
- Assert rst during SHIFT of 4321 -> no conv_done; the display returns to 0 and the outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/ssd_pkg.sv
// ssd_pkg: shared types, segment codes and helpers for the seven-segment display scheduler.
package ssd_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

   localparam int NUM_DIGITS = 4;
   localparam logic [6:0] SEG_OFF = 7'b1111111;
   localparam logic [3:0] ANODE_OFF = 4'b1111;

   // Active-low segment codes, ordered {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0: seg_of = SEG_0;
         4'd1: seg_of = SEG_1;
         4'd2: seg_of = SEG_2;
         4'd3: seg_of = SEG_3;
         4'd4: seg_of = SEG_4;
         4'd5: seg_of = SEG_5;
         4'd6: seg_of = SEG_6;
         4'd7: seg_of = SEG_7;
         4'd8: seg_of = SEG_8;
         4'd9: seg_of = SEG_9;
         default: seg_of = SEG_OFF;
      endcase
   endfunction

   function automatic logic [15:0] dabble_adjust(input logic [15:0] b);
      logic [15:0] a;
      for (int i = 0; i < NUM_DIGITS; i++)
         a[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
      return a;
   endfunction

endpackage

// File: rtl/ssd_display_scheduler_bcd_converter.sv
// bcd_converter: sequential double-dabble binary-to-BCD converter with valid/ready intake.
module bcd_converter
   import ssd_pkg::*;
#(
   parameter int DATA_W = 13
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] value_in,
   input  logic              value_valid,
   output logic              value_ready,
   output logic [15:0]       bcd_out,
   output logic              done
);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] bin_q, bin_d;
   logic [15:0]       bcd_q, bcd_d, adj;
   logic [3:0]        cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      bin_d       = bin_q;
      bcd_d       = bcd_q;
      cnt_d       = cnt_q;
      adj         = dabble_adjust(bcd_q);
      value_ready = state_q == IDLE;
      done        = state_q == COMMIT;
      case (state_q)
         IDLE: if (value_valid) begin
            bin_d   = value_in;
            bcd_d   = '0;
            cnt_d   = 4'(DATA_W);
            state_d = SHIFT;
         end
         SHIFT: begin
            // Binary MSB shifts into BCD bit 0 after the per-nibble add-3 correction
            {bcd_d, bin_d} = {adj, bin_q} << 1;
            cnt_d          = cnt_q - 4'd1;
            state_d        = (cnt_q == 4'd1) ? COMMIT : SHIFT;
         end
         COMMIT: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bcd_out = bcd_q;

endmodule

// File: rtl/ssd_display_scheduler.sv
// ssd_display_scheduler: converts a binary value to BCD and time-multiplexes it onto a
// 4-digit active-low seven-segment display with optional leading-zero blanking.
module ssd_display_scheduler
   import ssd_pkg::*;
#(
   parameter int DATA_W      = 13,
   parameter int REFRESH_DIV = 100000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] value_in,
   input  logic              value_valid,
   output logic              value_ready,
   output logic              conv_done,
   input  logic              blank_en,
   output logic [3:0]        anode,
   output logic [6:0]        seg
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam int IW = $clog2(NUM_DIGITS);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [15:0]   disp_q, disp_d, bcd;
   logic [3:0]    anode_q, anode_d, nib;
   logic [6:0]    seg_q, seg_d;
   logic          tc, lead_zero;

   bcd_converter #(.DATA_W(DATA_W)) u_conv (
      .clk         (clk),
      .rst         (rst),
      .value_in    (value_in),
      .value_valid (value_valid),
      .value_ready (value_ready),
      .bcd_out     (bcd),
      .done        (conv_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         disp_q  <= '0;
         anode_q <= ANODE_OFF;
         seg_q   <= SEG_OFF;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         disp_q  <= disp_d;
         anode_q <= anode_d;
         seg_q   <= seg_d;
      end
   end

   always_comb begin
      tc        = cnt_q == CW'(REFRESH_DIV - 1);
      cnt_d     = tc ? '0 : cnt_q + CW'(1);
      idx_d     = tc ? idx_q + IW'(1) : idx_q;
      disp_d    = conv_done ? bcd : disp_q;
      nib       = disp_q[{idx_q, 2'b00} +: 4];
      // A digit is a leading zero when it and every higher nibble are zero
      lead_zero = blank_en && (idx_q != '0) && ((disp_q >> {idx_q, 2'b00}) == 16'd0);
      anode_d   = tc ? ~(4'b0001 << idx_q) : anode_q;
      seg_d     = tc ? (lead_zero ? SEG_OFF : seg_of(nib)) : seg_q;
   end

   assign anode = anode_q;
   assign seg   = seg_q;

endmodule

// File: tb/tb_ssd_display_scheduler.sv
// tb_ssd_display_scheduler: randomized scoreboard bench with a decimal-arithmetic display model.
module tb_ssd_display_scheduler;

   localparam int DW = 13;
   localparam int RD = 4;
   localparam int LAT = DW + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] value_in = '0;
   logic          value_valid = 1'b0;
   logic          blank_en = 1'b0;
   logic          value_ready, conv_done;
   logic [3:0]    anode;
   logic [6:0]    seg;

   ssd_display_scheduler #(.DATA_W(DW), .REFRESH_DIV(RD)) dut (
      .clk         (clk),
      .rst         (rst),
      .value_in    (value_in),
      .value_valid (value_valid),
      .value_ready (value_ready),
      .conv_done   (conv_done),
      .blank_en    (blank_en),
      .anode       (anode),
      .seg         (seg)
   );

   always #5 clk = ~clk;

   typedef struct {int val; int done;} exp_t;
   exp_t q[$];

   int   total = 0, passed = 0;
   int   n = 0, last_done = -1, disp_m = 0, pend_val = 0, pend_e = 0;
   bit   pend_v = 0, in_rst = 1, blank_prev = 0, rdy_m = 1;
   logic [3:0] exp_an = 4'hF;
   logic [6:0] exp_seg = 7'h7F;
   logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s at edge %0d: got %0d expected %0d", name, n, act, exp);
   endtask

   // Monitor: n counts clock edges since the last reset edge; outputs are sampled mid-cycle
   always @(negedge clk) begin
      if (in_rst) begin
         q.delete();
         disp_m = 0; pend_v = 0; last_done = -1; n = 0; rdy_m = 1;
         exp_an = 4'hF; exp_seg = 7'h7F;
         check("rst_anode", int'(anode), 15);
         check("rst_seg", int'(seg), 127);
         check("rst_ready", int'(value_ready), 1);
         check("rst_done", int'(conv_done), 0);
      end else begin
         n++;
         if (pend_v && n > pend_e) begin
            disp_m = pend_val;
            pend_v = 0;
         end
         if (n % RD == 0) begin
            int i, p;
            i = (n / RD - 1) % 4;
            p = 10 ** i;
            exp_an  = ~(4'b0001 << i);
            exp_seg = (blank_prev && i > 0 && disp_m < p) ? 7'h7F : seg_tab[(disp_m / p) % 10];
         end
         check("anode", int'(anode), int'(exp_an));
         check("seg", int'(seg), int'(exp_seg));
         if (q.size() > 0 && q[0].done == n) begin
            check("conv_done", int'(conv_done), 1);
            pend_val  = q[0].val;
            pend_e    = n + 1;
            pend_v    = 1;
            last_done = n;
            void'(q.pop_front());
         end else begin
            check("conv_done", int'(conv_done), 0);
         end
         rdy_m = (q.size() == 0) && (n > last_done);
         check("ready", int'(value_ready), int'(rdy_m));
      end
      in_rst = rst;
      if (!rst && value_valid && rdy_m) begin
         exp_t e;
         e.val  = int'(value_in);
         e.done = n + LAT;
         q.push_back(e);
         rdy_m = 0;
      end
      blank_prev = blank_en;
   end

   task automatic idle(input int cycles);
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic send(input int v, input bit b);
      int  t;
      bit  got;
      t = 0;
      got = 0;
      value_in = DW'(v);
      blank_en = b;
      value_valid = 1'b1;
      do begin
         @(negedge clk);
         got = value_ready;
         @(posedge clk);
         #1;
         t++;
      end while (!got && t < 100);
      value_valid = 1'b0;
      check("handshake", int'(got), 1);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      idle(20);
      send(1234, 0);
      idle(24);
      send(8191, 0);
      idle(20);
      send(0, 1);
      idle(24);
      send(1234, 1);
      idle(20);
      send(5, 1);
      idle(20);
      value_in = DW'(100);
      value_valid = 1'b1;
      repeat (40) begin
         @(posedge clk);
         #1 value_in = DW'($urandom_range(0, 8191));
      end
      value_valid = 1'b0;
      idle(24);
      send(4321, 0);
      idle(5);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      idle(24);
      send(9, 0);
      idle(2);
      value_in = DW'(77);
      value_valid = 1'b1;
      idle(3);
      value_valid = 1'b0;
      idle(20);
      repeat (12) begin
         send(int'($urandom_range(0, 8191)), 1'($urandom_range(0, 1)));
         idle(int'($urandom_range(14, 40)));
      end
      idle(2 * LAT);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
